attn_out_collector: RTL and testbench
=====================================

Name: attn_out_collector

Overview:
- Receiver/sink for the attention top's result stream: out_valid, out_row[1:0], out_group[4:0], out_data[127:0] and the done pulse.
- Captures one full 4-row x 32-group FP32 result frame (128 beats of 128 bits) into a local buffer at address {row,group}.
- Checks that the frame is complete and unique.
- After the frame completes, exposes the buffer through a fixed-latency read port for the host or the next layer.

Parameters:
- READ_LAT, 2, read latency in cycles from rd_en to rd_valid; legal values 1..4.
- TOTAL_BEATS, 128, unique beats that complete a frame; equals ROWS*GROUPS.
- ROWS, 4, rows per frame; in_row width is clog2(ROWS).
- GROUPS, 32, 4-lane groups per row; in_group width is clog2(GROUPS).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous active-high reset.
- arm  in  1  single-cycle pulse that starts capture of a new frame.
- in_valid  in  1  result beat valid; connects to the top's out_valid.
- in_row  in  2  row index of the beat.
- in_group  in  5  group index of the beat; head = in_group[4:3].
- in_data  in  128  four FP32 lanes; lane0 = [31:0].
- in_done  in  1  top's done pulse.
- rd_en  in  1  read request.
- rd_addr  in  7  read address = row*32 + group.
- rd_valid  out  1  read data valid.
- rd_data  out  128  read data.
- busy  out  1  high in CAPTURE.
- frame_done  out  1  one-cycle pulse on entry to COMPLETE.
- beat_count  out  8  number of unique beats captured in the current frame.
- dup_err  out  1  sticky per frame: a beat arrived at an address already written.
- miss_err  out  1  sticky per frame: in_done arrived before TOTAL_BEATS unique beats.
- stray_err  out  1  sticky per frame: in_valid arrived outside CAPTURE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including the three error flags and the read pipeline.
  - Valid bitmap clears to 0.
  - Buffer contents are not reset.
  - Reset in the middle of a capture abandons the frame; no frame_done pulse is produced.
- States: IDLE, CAPTURE, COMPLETE.
- IDLE:
  - arm: go to CAPTURE; clear bitmap, beat_count and all error flags.
- CAPTURE:
  - in_valid: write in_data to mem[{in_row,in_group}].
  - If the bitmap bit for that address is already set, set dup_err. The new data overwrites the old. beat_count is unchanged.
  - Otherwise set the bitmap bit and increment beat_count.
  - When beat_count reaches TOTAL_BEATS, go to COMPLETE on the next edge and pulse frame_done for one cycle.
  - in_done with beat_count < TOTAL_BEATS: go to COMPLETE, set miss_err, pulse frame_done.
  - in_done in the same cycle as the final unique beat: the beat counts, miss_err stays 0, and frame_done pulses only once.
  - arm is ignored.
- COMPLETE:
  - Buffer is readable.
  - arm: go to CAPTURE and clear the counters, bitmap and flags as in IDLE.
  - in_done is ignored.
- in_valid in IDLE or COMPLETE: beat is dropped, buffer is not written, stray_err is set.
- Read port:
  - rd_en is accepted only in COMPLETE.
  - Accepted read: rd_valid=1 exactly READ_LAT cycles later, with rd_data = mem[rd_addr] as of the rd_en cycle.
  - Back-to-back rd_en gives one result per cycle.
  - Reads already in flight complete even if arm moves the state to CAPTURE.
  - rd_en outside COMPLETE: no rd_valid is produced.
  - rd_data holds its last value when rd_valid=0.
- Widths and storage:
  - Buffer is 128 x 128 single-write-port storage.
  - Write and read in the same cycle cannot collide, because writes happen only in CAPTURE and reads are accepted only in COMPLETE.
  - beat_count saturates at TOTAL_BEATS.

Optional Feature:
- Macro: ATTN_COLLECT_NAN_CHK_EN.
- Defined:
  - Adds output nan_err (1 bit), sticky per frame, cleared by arm and rst.
  - nan_err is set when any lane of an accepted CAPTURE beat has exponent 8'hFF, i.e. FP32 Inf or NaN.
  - Adds output nan_first_addr (7 bits): address of the first such beat in the frame. It resets to 0.
- Not defined: neither port exists and no exponent decode logic is built.

Test Plan:
- Full frame: arm, then 128 in-order beats with in_data[31:0]=addr (FP32 bit pattern), 1 beat/cycle, then in_done.
  - frame_done pulses once, 1 cycle after the beat with addr=127.
  - beat_count=128; dup_err, miss_err and stray_err are all 0.
  - Reading all 128 addresses back-to-back returns addr in lane0, with rd_valid READ_LAT cycles after each rd_en.
- Shuffled order with gaps: beats sent in reverse address order, with in_valid toggling every other cycle.
  - Completes with beat_count=128.
  - rd_addr=37 (row1, group5) returns that beat's data.
- Duplicate: resend addr 10 with new data 32'h3f800000, before the last beat.
  - dup_err=1, beat_count=127.
  - in_done then sets miss_err=1; reading addr 10 returns 3f800000.
- Final beat and in_done in the same cycle: frame_done pulses exactly once and miss_err=0.
- Stray and early reads:
  - in_valid in IDLE gives stray_err=1 and the buffer is unchanged.
  - rd_en during CAPTURE produces no rd_valid.
  - rst asserted mid-capture (at beat 60) clears beat_count and busy to 0 on the next edge, with no frame_done.
- With ATTN_COLLECT_NAN_CHK_EN: lane2 = 32'h7fc00000 at addr 90, then lane0 = 32'h7f800000 at addr 100.
  - nan_err=1 and nan_first_addr=90.
  - A new arm clears both.

Source files
------------

// File: rtl/attn_out_collector.sv
// Sink for the attention result stream: captures one 4x32 frame of 128-bit beats,
// checks completeness/uniqueness, then serves a fixed-latency read port.
// Optional Inf/NaN detection is built when ATTN_COLLECT_NAN_CHK_EN is defined.
module attn_out_collector #(
  parameter int READ_LAT    = 2,
  parameter int TOTAL_BEATS = 128,
  parameter int ROWS        = 4,
  parameter int GROUPS      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm,
  input  logic                      in_valid,
  input  logic [$clog2(ROWS)-1:0]   in_row,
  input  logic [$clog2(GROUPS)-1:0] in_group,
  input  logic [127:0]              in_data,
  input  logic                      in_done,
  input  logic                      rd_en,
  input  logic [$clog2(ROWS)+$clog2(GROUPS)-1:0] rd_addr,
  output logic                      rd_valid,
  output logic [127:0]              rd_data,
  output logic                      busy,
  output logic                      frame_done,
  output logic [7:0]                beat_count,
  output logic                      dup_err,
  output logic                      miss_err,
`ifdef ATTN_COLLECT_NAN_CHK_EN
  output logic                      stray_err,
  output logic                      nan_err,
  output logic [$clog2(ROWS)+$clog2(GROUPS)-1:0] nan_first_addr
`else
  output logic                      stray_err
`endif
);
  localparam int AW    = $clog2(ROWS) + $clog2(GROUPS);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_COMPLETE} state_t;

  state_t           r_state, w_state_nxt;
  logic [127:0]     r_mem [0:DEPTH-1];
  logic [DEPTH-1:0] r_vmap;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic             r_dup, r_miss, r_stray, r_fdone;
  logic             w_enter_cmp, w_cap_beat, w_new, w_full, w_arm_clr;
  logic [AW-1:0]    w_waddr;

  assign w_waddr    = {in_row, in_group};
  assign w_cap_beat = in_valid && (r_state == S_CAPTURE);
  assign w_new      = w_cap_beat && !r_vmap[w_waddr] && (r_cnt != 8'(TOTAL_BEATS));
  assign w_cnt_nxt  = r_cnt + 8'(w_new);
  assign w_full     = (w_cnt_nxt == 8'(TOTAL_BEATS));
  assign w_arm_clr  = arm && (r_state != S_CAPTURE);

  always_comb begin
    w_state_nxt = r_state;
    w_enter_cmp = 1'b0;
    case (r_state)
      S_IDLE:     if (arm) w_state_nxt = S_CAPTURE;
      S_CAPTURE:  if (w_full || in_done) begin
                    w_state_nxt = S_COMPLETE;
                    w_enter_cmp = 1'b1;
                  end
      S_COMPLETE: if (arm) w_state_nxt = S_CAPTURE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A final unique beat arriving with in_done fills the frame, so it is not a miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vmap  <= '0;
      r_cnt   <= '0;
      r_dup   <= 1'b0;
      r_miss  <= 1'b0;
      r_stray <= 1'b0;
      r_fdone <= 1'b0;
    end else begin
      r_fdone <= w_enter_cmp;
      if (w_arm_clr) begin
        r_vmap  <= '0;
        r_cnt   <= '0;
        r_dup   <= 1'b0;
        r_miss  <= 1'b0;
        r_stray <= 1'b0;
      end else begin
        if (w_cap_beat) begin
          if (r_vmap[w_waddr]) r_dup <= 1'b1;
          else                 r_vmap[w_waddr] <= 1'b1;
        end
        r_cnt <= w_cnt_nxt;
        if ((r_state == S_CAPTURE) && in_done && !w_full) r_miss <= 1'b1;
        if (in_valid && (r_state != S_CAPTURE)) r_stray <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap_beat) r_mem[w_waddr] <= in_data;
  end

  // Read pipe: stage 0 is the combinational array read; data stages only load on valid
  // so rd_data holds its last value between reads.
  logic                w_rd_acc;
  logic [READ_LAT:1]   r_vld_pipe;
  logic [READ_LAT:0]   w_vld;
  logic [127:0]        w_rd_dat [0:READ_LAT];

  assign w_rd_acc    = rd_en && (r_state == S_COMPLETE);
  assign w_vld       = {r_vld_pipe, w_rd_acc};
  assign w_rd_dat[0] = r_mem[rd_addr];

  always_ff @(posedge clk) begin
    if (rst) r_vld_pipe <= '0;
    else     r_vld_pipe <= w_vld[READ_LAT-1:0];
  end

  for (genvar g = 1; g <= READ_LAT; g++) begin : g_rd_stage
    logic [127:0] r_stage;
    always_ff @(posedge clk) begin
      if (rst)             r_stage <= '0;
      else if (w_vld[g-1]) r_stage <= w_rd_dat[g-1];
    end
    assign w_rd_dat[g] = r_stage;
  end

`ifdef ATTN_COLLECT_NAN_CHK_EN
  logic          r_nan, w_nan_hit;
  logic [AW-1:0] r_nan_addr;

  always_comb begin
    w_nan_hit = 1'b0;
    for (int l = 0; l < 4; l++)
      if (in_data[32*l+23 +: 8] == 8'hFF) w_nan_hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || w_arm_clr) begin
      r_nan      <= 1'b0;
      r_nan_addr <= '0;
    end else if (w_cap_beat && w_nan_hit && !r_nan) begin
      r_nan      <= 1'b1;
      r_nan_addr <= w_waddr;
    end
  end

  assign nan_err        = r_nan;
  assign nan_first_addr = r_nan_addr;
`endif

  assign rd_valid   = w_vld[READ_LAT];
  assign rd_data    = w_rd_dat[READ_LAT];
  assign busy       = (r_state == S_CAPTURE);
  assign frame_done = r_fdone;
  assign beat_count = r_cnt;
  assign dup_err    = r_dup;
  assign miss_err   = r_miss;
  assign stray_err  = r_stray;
endmodule

// File: tb/tb_attn_out_collector.sv
// Directed bench for attn_out_collector: reference buffer model plus a read scoreboard
// that checks data and latency of every rd_valid.
module tb_attn_out_collector;
  localparam int RL = 2;

  logic         clk = 1'b0;
  logic         rst, arm, in_valid, in_done, rd_en;
  logic [1:0]   in_row;
  logic [4:0]   in_group;
  logic [127:0] in_data;
  logic [6:0]   rd_addr;
  logic         rd_valid, busy, frame_done, dup_err, miss_err, stray_err;
  logic [127:0] rd_data;
  logic [7:0]   beat_count;
`ifdef ATTN_COLLECT_NAN_CHK_EN
  logic         nan_err;
  logic [6:0]   nan_first_addr;
`endif

  attn_out_collector #(.READ_LAT(RL)) dut (
    .clk(clk), .rst(rst), .arm(arm), .in_valid(in_valid), .in_row(in_row),
    .in_group(in_group), .in_data(in_data), .in_done(in_done), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .frame_done(frame_done), .beat_count(beat_count), .dup_err(dup_err),
    .miss_err(miss_err),
`ifdef ATTN_COLLECT_NAN_CHK_EN
    .stray_err(stray_err), .nan_err(nan_err), .nan_first_addr(nan_first_addr)
`else
    .stray_err(stray_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [127:0] d; } exp_t;
  exp_t         sb[$];
  logic [127:0] exp_mem [128];
  int           cyc = 0, n_pass = 0, n_chk = 0, fd_cnt = 0, fd0 = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) chk("rd_unexpected", 128'(sb.size()), 128'd1);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_data", rd_data, e.d);
        chk("rd_latency", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  function automatic logic [127:0] mk(int a, int f);
    return {32'(a) ^ 32'h0055AA00, 32'(a * 3), 32'(f), 32'(a)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic beat(int a, logic [127:0] d, bit wr);
    in_valid = 1'b1; {in_row, in_group} = 7'(a); in_data = d;
    if (wr) exp_mem[a] = d;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask
  task automatic pulse_done();
    in_done = 1'b1; tick(); in_done = 1'b0;
  endtask
  task automatic rd(int a);
    exp_t e;
    e.cyc = cyc + RL; e.d = exp_mem[a];
    sb.push_back(e);
    rd_en = 1'b1; rd_addr = 7'(a);
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [127:0] d;
    rst = 1'b1; arm = 0; in_valid = 0; in_done = 0; rd_en = 0;
    in_row = 0; in_group = 0; in_data = '0; rd_addr = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);       chk("rst_fdone", frame_done, 0);
    chk("rst_count", beat_count, 0); chk("rst_dup", dup_err, 0);
    chk("rst_miss", miss_err, 0);   chk("rst_stray", stray_err, 0);
    chk("rst_rdvalid", rd_valid, 0); chk("rst_rddata", rd_data, 0);

    // full in-order frame
    pulse_arm();
    chk("t1_busy", busy, 1);
    fd0 = fd_cnt;
    for (int a = 0; a < 128; a++) begin
      beat(a, mk(a, 1), 1'b1);
      if (a == 126) chk("t1_fd_early", frame_done, 0);
    end
    chk("t1_fd", frame_done, 1);
    chk("t1_busy_off", busy, 0);
    pulse_done();
    chk("t1_fd_once", frame_done, 0);
    chk("t1_fd_cnt", 128'(fd_cnt - fd0), 1);
    chk("t1_count", beat_count, 128);
    chk("t1_dup", dup_err, 0); chk("t1_miss", miss_err, 0); chk("t1_stray", stray_err, 0);
    for (int a = 0; a < 128; a++) rd(a);
    repeat (RL + 2) tick();
    chk("t1_sb_empty", 128'(sb.size()), 0);
    chk("t1_rd_hold", rd_data, exp_mem[127]);

    // reverse order with gaps
    pulse_arm();
    for (int a = 127; a >= 0; a--) begin
      beat(a, mk(a, 2), 1'b1);
      if (a != 0) tick();
    end
    chk("t2_fd", frame_done, 1);
    chk("t2_count", beat_count, 128);
    chk("t2_dup", dup_err, 0);
    rd(37);
    repeat (RL + 2) tick();

    // duplicate beat, then early done
    pulse_arm();
    for (int a = 0; a < 127; a++) begin
      beat(a, mk(a, 3), 1'b1);
      if (a == 60) beat(10, {96'h0, 32'h3f800000}, 1'b1);
    end
    chk("t3_dup", dup_err, 1);
    chk("t3_count", beat_count, 127);
    chk("t3_busy", busy, 1);
    pulse_done();
    chk("t3_fd", frame_done, 1);
    chk("t3_miss", miss_err, 1);
    rd(10);
    repeat (RL + 2) tick();

    // final beat coincides with done
    pulse_arm();
    fd0 = fd_cnt;
    for (int a = 0; a < 127; a++) beat(a, mk(a, 4), 1'b1);
    in_done = 1'b1;
    beat(127, mk(127, 4), 1'b1);
    in_done = 1'b0;
    chk("t4_fd", frame_done, 1);
    chk("t4_miss", miss_err, 0);
    chk("t4_count", beat_count, 128);
    tick();
    chk("t4_fd_off", frame_done, 0);
    chk("t4_fd_cnt", 128'(fd_cnt - fd0), 1);

    // read during capture, reset mid-capture, stray beat in IDLE
    pulse_arm();
    for (int a = 0; a < 3; a++) beat(a, mk(a, 5), 1'b1);
    rd_en = 1'b1; rd_addr = 7'd3;
    tick();
    rd_en = 1'b0;
    repeat (RL + 1) begin
      tick();
      chk("t5_no_rdvalid", rd_valid, 0);
    end
    for (int a = 3; a < 60; a++) beat(a, mk(a, 5), 1'b1);
    fd0 = fd_cnt;
    rst = 1'b1;
    beat(60, mk(60, 5), 1'b0);
    rst = 1'b0;
    chk("t5_rst_count", beat_count, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_fd", frame_done, 0);
    tick();
    chk("t5_rst_fd_cnt", 128'(fd_cnt - fd0), 0);
    beat(100, mk(100, 9), 1'b0);
    chk("t5_stray", stray_err, 1);
    chk("t5_stray_count", beat_count, 0);
    pulse_arm();
    chk("t5_arm_clr", stray_err, 0);
    beat(0, mk(0, 6), 1'b1);
    pulse_done();
    chk("t5_fd", frame_done, 1);
    chk("t5_miss", miss_err, 1);
    chk("t5_count", beat_count, 1);
    rd(100);
    rd(30);
    repeat (RL + 2) tick();

`ifdef ATTN_COLLECT_NAN_CHK_EN
    pulse_arm();
    chk("nan_clr0", nan_err, 0);
    beat(5, mk(5, 7), 1'b1);
    chk("nan_none", nan_err, 0);
    d = mk(90, 7); d[95:64] = 32'h7fc00000;
    beat(90, d, 1'b1);
    beat(95, mk(95, 7), 1'b1);
    d = mk(100, 7); d[31:0] = 32'h7f800000;
    beat(100, d, 1'b1);
    chk("nan_err", nan_err, 1);
    chk("nan_addr", nan_first_addr, 90);
    pulse_done();
    pulse_arm();
    chk("nan_arm_err", nan_err, 0);
    chk("nan_arm_addr", nan_first_addr, 0);
`else
    d = '0;
`endif

    chk("sb_final_empty", 128'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
